decode_stage: RTL and testbench

Registered RV32 decode stage and the successor to the team's combinational field splitter. It sits between the fetch stage and the register-file/execute stage. It accepts one 32-bit instruction per handshake and extracts every field. It also generates the sign-extended immediate for all base formats, derives register-file enables, and presents the result through a one-entry valid/ready pipeline register with flush.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/imm_gen.sv | 41 ++++
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: base opcodes, immediate format codes and the
// control half of the decoded bundle.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    // Everything in the registered bundle that does not scale with a parameter.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] func3;
        logic [6:0] func7;
        imm_fmt_e   imm_fmt;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_we;
        logic       illegal;
    } dec_ctrl_t;

    function automatic logic is_rv32i_opcode(input logic [6:0] opc);
        logic hit;
        hit = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the RV32 immediate for the given
// format and sign-extends it to DATA_WIDTH (R and unknown formats give zero).
module imm_gen
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr_in,
    input  logic [2:0]            imm_fmt,
    output logic [DATA_WIDTH-1:0] imm_value
);

    logic [31:0] w_raw;
    logic        w_unused;

    // The opcode bits never contribute to an immediate.
    assign w_unused = &{1'b0, instr_in[6:0]};

    always_comb begin
        w_raw = '0;
        case (imm_fmt)
            FMT_I:   w_raw = {{20{instr_in[31]}}, instr_in[31:20]};
            FMT_S:   w_raw = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            FMT_B:   w_raw = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                              instr_in[30:25], instr_in[11:8], 1'b0};
            FMT_U:   w_raw = {instr_in[31:12], 12'b0};
            FMT_J:   w_raw = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                              instr_in[20], instr_in[30:21], 1'b0};
            default: w_raw = '0;
        endcase
    end

    generate
        if (DATA_WIDTH > 32) begin : g_wide
            assign imm_value = {{(DATA_WIDTH-32){w_raw[31]}}, w_raw};
        end else begin : g_narrow
            assign imm_value = w_raw;
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage with a one-entry valid/ready output register and flush.
// Optional: define DECODE_ILLEGAL_CHECK_EN to build the illegal-encoding check.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [ADD_WIDTH-1:0]  add_rs1,
    output logic [ADD_WIDTH-1:0]  add_rs2,
    output logic [ADD_WIDTH-1:0]  add_rd,
    output logic [6:0]            opcode,
    output logic [2:0]            func3,
    output logic [6:0]            func7,
    output logic [DATA_WIDTH-1:0] imm_value,
    output logic [2:0]            imm_fmt,
    output logic                  rs1_used,
    output logic                  rs2_used,
    output logic                  rd_we,
    output logic                  illegal
);

    imm_fmt_e              w_fmt;
    logic                  w_rs1_used;
    logic                  w_rs2_used;
    logic                  w_rd_class;
    logic                  w_illegal;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_imm;
    dec_ctrl_t             w_ctrl;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [ADD_WIDTH-1:0]  r_rs1;
    logic [ADD_WIDTH-1:0]  r_rs2;
    logic [ADD_WIDTH-1:0]  r_rd;
    logic [DATA_WIDTH-1:0] r_imm;
    dec_ctrl_t             r_ctrl;

    // Format and register-file usage are decided purely by the opcode class.
    always_comb begin
        w_fmt      = FMT_R;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rd_class = 1'b0;
        case (instr_in[6:0])
            OPC_OP: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_rd_class = 1'b1;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
                w_fmt      = FMT_I;
                w_rs1_used = 1'b1;
                w_rd_class = 1'b1;
            end
            OPC_STORE: begin
                w_fmt      = FMT_S;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                w_fmt      = FMT_B;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_fmt      = FMT_U;
                w_rd_class = 1'b1;
            end
            OPC_JAL: begin
                w_fmt      = FMT_J;
                w_rd_class = 1'b1;
            end
            default: begin
                w_fmt = FMT_R;
            end
        endcase
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign w_illegal = (instr_in[1:0] != 2'b11) || !is_rv32i_opcode(instr_in[6:0]);
`else
    assign w_illegal = 1'b0;
`endif

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instr_in  (instr_in),
        .imm_fmt   (w_fmt),
        .imm_value (w_imm)
    );

    always_comb begin
        w_ctrl          = '0;
        w_ctrl.opcode   = instr_in[6:0];
        w_ctrl.func3    = instr_in[14:12];
        w_ctrl.func7    = instr_in[31:25];
        w_ctrl.imm_fmt  = w_fmt;
        w_ctrl.rs1_used = w_rs1_used;
        w_ctrl.rs2_used = w_rs2_used;
        // Writes to x0 are discarded, so never request them.
        w_ctrl.rd_we    = w_rd_class && (instr_in[11:7] != 5'd0) && !w_illegal;
        w_ctrl.illegal  = w_illegal;
    end

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= pc_in;
            r_rs1       <= ADD_WIDTH'(instr_in[19:15]);
            r_rs2       <= ADD_WIDTH'(instr_in[24:20]);
            r_rd        <= ADD_WIDTH'(instr_in[11:7]);
            r_imm       <= w_imm;
            r_ctrl      <= w_ctrl;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign pc_out    = r_pc;
    assign add_rs1   = r_rs1;
    assign add_rs2   = r_rs2;
    assign add_rd    = r_rd;
    assign imm_value = r_imm;
    assign opcode    = r_ctrl.opcode;
    assign func3     = r_ctrl.func3;
    assign func7     = r_ctrl.func7;
    assign imm_fmt   = r_ctrl.imm_fmt;
    assign rs1_used  = r_ctrl.rs1_used;
    assign rs2_used  = r_ctrl.rs2_used;
    assign rd_we     = r_ctrl.rd_we;
    assign illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a reference model.
module tb_decode_stage;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    localparam logic [6:0] OPCS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr_in;
    logic [DW-1:0] pc_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] pc_out;
    logic [AW-1:0] add_rs1;
    logic [AW-1:0] add_rs2;
    logic [AW-1:0] add_rd;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic [6:0]    func7;
    logic [DW-1:0] imm_value;
    logic [2:0]    imm_fmt;
    logic          rs1_used;
    logic          rs2_used;
    logic          rd_we;
    logic          illegal;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        rs1u;
        logic        rs2u;
        logic        rdwe;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bundle_t     exp;
    } vec_t;

    int      n_tests;
    int      n_fail;
    bundle_t q[$];

    decode_stage #(
        .ADD_WIDTH  (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_in  (instr_in),
        .pc_in     (pc_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .add_rs1   (add_rs1),
        .add_rs2   (add_rs2),
        .add_rd    (add_rd),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .imm_value (imm_value),
        .imm_fmt   (imm_fmt),
        .rs1_used  (rs1_used),
        .rs2_used  (rs2_used),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bundle_t act();
        bundle_t b;
        b.pc   = pc_out;
        b.rs1  = add_rs1;
        b.rs2  = add_rs2;
        b.rd   = add_rd;
        b.opc  = opcode;
        b.f3   = func3;
        b.f7   = func7;
        b.imm  = imm_value;
        b.fmt  = imm_fmt;
        b.rs1u = rs1_used;
        b.rs2u = rs2_used;
        b.rdwe = rd_we;
        b.ill  = illegal;
        return b;
    endfunction

    function automatic bundle_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm,
                                   input logic [2:0] fmt, input logic rs1u,
                                   input logic rs2u, input logic rdwe, input logic ill);
        bundle_t b;
        b = '{pc: pc, rs1: rs1, rs2: rs2, rd: rd, opc: opc, f3: f3, f7: f7, imm: imm,
              fmt: fmt, rs1u: rs1u, rs2u: rs2u, rdwe: rdwe, ill: ill};
        return b;
    endfunction

    // Reference decode: fields by shift/modulo, immediates by signed arithmetic.
    function automatic bundle_t model(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t     b;
        int unsigned u;
        int          v;
        int          cls;   // 0 other, 1 OP, 2 I, 3 S, 4 B, 5 U, 6 J
        logic        legal;
        u      = instr;
        b.pc   = pc;
        b.opc  = 7'(u % 128);
        b.rd   = 5'((u >> 7) % 32);
        b.f3   = 3'((u >> 12) % 8);
        b.rs1  = 5'((u >> 15) % 32);
        b.rs2  = 5'((u >> 20) % 32);
        b.f7   = 7'(u >> 25);
        case (b.opc)
            7'h33:                      cls = 1;
            7'h03, 7'h13, 7'h67, 7'h73: cls = 2;
            7'h23:                      cls = 3;
            7'h63:                      cls = 4;
            7'h37, 7'h17:               cls = 5;
            7'h6F:                      cls = 6;
            default:                    cls = 0;
        endcase
        legal = (u % 4 == 3) && (b.opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                               7'h23, 7'h13, 7'h33, 7'h0F, 7'h73});
        b.ill = ILL_EN && !legal;
        v = 0;
        case (cls)
            2: begin
                v = int'(u >> 20);
                if (v >= 2048) v = v - 4096;
            end
            3: begin
                v = int'((u >> 25) * 32 + ((u >> 7) % 32));
                if (v >= 2048) v = v - 4096;
            end
            4: begin
                v = int'(((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
                         + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2);
                if (v >= 4096) v = v - 8192;
            end
            5: v = int'(u - (u % 4096));
            6: begin
                v = int'(((u >> 31) % 2) * 1048576 + ((u >> 12) % 256) * 4096
                         + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2);
                if (v >= 1048576) v = v - 2097152;
            end
            default: v = 0;
        endcase
        b.imm  = v;
        b.fmt  = (cls == 0) ? 3'd0 : 3'(cls - 1);
        b.rs1u = (cls >= 1) && (cls <= 4);
        b.rs2u = (cls == 1) || (cls == 3) || (cls == 4);
        b.rdwe = (cls == 1 || cls == 2 || cls == 5 || cls == 6) && (b.rd != 0) && !b.ill;
        return b;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_bundle(input string name, input bundle_t got, input bundle_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string name);
        check_bit({name, " out_valid"}, out_valid, 1'b0);
        check_bit({name, " in_ready"}, in_ready, 1'b1);
        check_bundle({name, " outputs"}, act(), '0);
    endtask

    // One cycle: entered at posedge+1, checks outputs, drives inputs, updates the
    // scoreboard at the negedge and returns at the next posedge+1.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, output logic acc);
        logic exp_ready;
        check_bit("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check_bundle("bundle", act(), q[0]);
        in_valid  = iv;
        instr_in  = ins;
        pc_in     = pc;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        exp_ready = (q.size() == 0) || ordy;
        check_bit("in_ready", in_ready, exp_ready);
        acc = iv && exp_ready && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) begin
                $display("[TB] txn pc=%h opc=%h fmt=%0d imm=%h", q[0].pc, q[0].opc,
                         q[0].fmt, q[0].imm);
                void'(q.pop_front());
            end
            if (acc) q.push_back(model(ins, pc));
        end
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[8];
    logic        acc;
    logic [31:0] stream[5];
    int          idx;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [6:0]  opc;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr_in  = '0;
        pc_in     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{32'hFFF10093, 32'h1000, mk(32'h1000, 2, 31, 1, 7'h13, 0, 7'h7F, 32'hFFFFFFFF, 1, 1, 0, 1, 0)};
        vecs[1] = '{32'h00512423, 32'h1004, mk(32'h1004, 2, 5, 8, 7'h23, 2, 0, 32'h8, 2, 1, 1, 0, 0)};
        vecs[2] = '{32'hFE000EE3, 32'h1008, mk(32'h1008, 0, 0, 5'h1D, 7'h63, 0, 7'h7F, 32'hFFFFFFFC, 3, 1, 1, 0, 0)};
        vecs[3] = '{32'h123451B7, 32'h100C, mk(32'h100C, 8, 3, 3, 7'h37, 5, 9, 32'h12345000, 4, 0, 0, 1, 0)};
        vecs[4] = '{32'h002081B3, 32'h1010, mk(32'h1010, 1, 2, 3, 7'h33, 0, 0, 32'h0, 0, 1, 1, 1, 0)};
        vecs[5] = '{32'hFF9FF06F, 32'h1014, mk(32'h1014, 31, 25, 0, 7'h6F, 7, 7'h7F, 32'hFFFFFFF8, 5, 0, 0, 0, 0)};
        vecs[6] = '{32'h0FF0008F, 32'h1018, mk(32'h1018, 0, 31, 1, 7'h0F, 0, 7, 32'h0, 0, 0, 0, 0, 0)};
        vecs[7] = '{32'h00000000, 32'h101C, mk(32'h101C, 0, 0, 0, 7'h00, 0, 0, 32'h0, 0, 0, 0, 0, ILL_EN)};

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0, acc);
            check_bit($sformatf("vec%0d valid", i), out_valid, 1'b1);
            check_bundle($sformatf("vec%0d", i), act(), vecs[i].exp);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Back-to-back stream with a two-cycle downstream stall.
        stream = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(idx < 5, (idx < 5) ? stream[idx] : 32'h0, 32'h2000 + 32'(idx * 4),
                 !(c == 2 || c == 3), 1'b0, acc);
            if (acc) idx++;
        end
        check_bit("stream all accepted", idx == 5, 1'b1);

        // Flush while a bundle is stalled, with a new instruction offered.
        step(1'b1, 32'h00A00513, 32'h3000, 1'b1, 1'b0, acc);
        step(1'b1, 32'h00B00593, 32'h3004, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00C00613, 32'h3008, 1'b0, 1'b1, acc);
        check_bit("flush drops", out_valid, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Asynchronous reset in the middle of a held bundle.
        step(1'b1, 32'h00D00693, 32'h4000, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            r1 = $urandom;
            r2 = $urandom;
            opc = (r2[3:0] < 4'd12) ? OPCS[r2[7:4] % 11] : r2[14:8];
            step(r2[17:16] != 2'b00, {r1[31:7], opc}, $urandom,
                 r2[19:18] != 2'b00, r2[23:20] == 4'h0, acc);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
